fpu_mul_arbiter: RTL
====================

# fpu_mul_arbiter

Controller that shares the single pipelined FPU multiply datapath (the 24×24 significand multiplier followed by the multiply normalizer) between two requesters, e.g. the FMUL issue path and the FMADD sequencer. It arbitrates requests round-robin and drives operands into the multiplier. It delays each operation's pre-normalisation exponent and underflow flag so they reach the normalizer in the same cycle as the product. Normalised results are captured into a credit-protected output FIFO and returned with requester ID and tag under valid/ready handshake.

## Interface
- MUL_LAT, 2: clocked multiplier latency in cycles, from operands in to product out (≥1).
- TAG_W, 5: width of the requester-supplied tag.
- Localparam FIFO_DEPTH = MUL_LAT+2.

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- reqN_valid  in  1  request N ∈ {0,1} valid
- reqN_ready  out  1  request N accepted this cycle when high with valid
- reqN_tag  in  TAG_W  opaque tag
- reqN_exp  in  9  biased pre-normalisation exponent
- reqN_uf  in  1  exponent-underflow flag
- reqN_sigA / reqN_sigB  in  24  significands with hidden bit
- mul_sig_A / mul_sig_B  out  24  to multiplier
- mul_preNorm_exp  out  9  to normalizer, aligned with product
- mul_is_exp_underFlow  out  1  to normalizer, aligned with product
- mul_proNorm_sig  in  26  from normalizer
- mul_proNorm_exp  in  8  from normalizer
- mul_of / mul_uf  in  1  normalizer overflow/underflow
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts
- rsp_id  out  1  originating requester
- rsp_tag  out  TAG_W, rsp_sig  out  26, rsp_exp  out  8, rsp_of / rsp_uf  out  1  result fields

## Operation
- Credit: count = in-flight ops + FIFO occupancy. The arbiter may grant only when count < FIFO_DEPTH. Same-cycle pops are not credited.
- Arbitration: round-robin. A last-grant pointer resets to 1, so req0 wins the first contention. When both are valid, grant the requester not granted last. The pointer updates only on a grant. A single valid requester is granted whenever credit allows.
- reqN_ready = credit_ok & (grant==N). Ready may depend on the other requester's valid. Both readies are never high together.
- On grant, mul_sig_A/B = granted sigA/sigB combinationally in the same cycle. With no grant they are 0.
- Metadata shift register, MUL_LAT stages, carries {valid, id, tag, exp, uf}.
  - Its last stage drives mul_preNorm_exp and mul_is_exp_underFlow.
  - When that stage is invalid, both outputs are 0.
- At the end of a cycle whose last stage is valid, push {id, tag, mul_proNorm_sig, mul_proNorm_exp, mul_of, mul_uf} into the FIFO. The credit rule guarantees the FIFO is never full on a push.
- FIFO: head registered onto rsp_* outputs. rsp_valid = non-empty. A pop occurs on rsp_valid & rsp_ready. Push and pop may occur in the same cycle. Pointers wrap modulo FIFO_DEPTH.
- Results return in grant order; there is no reordering.

## Timing
- Grant at cycle t:
  - product and aligned exponent at the normalizer in cycle t+MUL_LAT
  - FIFO write at the end of t+MUL_LAT
  - rsp_valid earliest at t+MUL_LAT+1
- Throughput is 1 op/cycle sustained while rsp_ready stays high.
- Backpressure (rsp_ready low): grants continue until count reaches FIFO_DEPTH, then both readies drop. In-flight ops always land.
- Reset, including mid-operation, must:
  - clear all metadata valid bits, FIFO pointers and count
  - set the round-robin pointer to 1
- Output values while reset is high, and in the first cycle after it deasserts with no request:
  - rsp_valid=0
  - all rsp_* fields 0
  - mul_* outputs 0
  - reqN_ready=0 while reset is high
- Products arriving after reset are ignored because the metadata was cleared.

## Configuration
- FPU_MUL_FLUSH_EN defined: adds input port flush (1 bit).
  - While flush is high, no grant is made and both readies are low.
  - At the cycle end, all metadata valid bits, the FIFO and the count clear, so rsp_valid=0 in the next cycle.
  - The round-robin pointer is preserved.
- Not defined: no flush port. Only reset clears state.

## Test plan
- MUL_LAT=2; req0 alone, sigA=sigB=24'h800000 (1.0), exp=127, uf=0, tag=3, granted at t -> mul_preNorm_exp=127 at t+2; rsp_valid at t+3 with id=0, tag=3, exp=127, of=0.
- Both valid every cycle for 6 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1 starting with 0; responses are in the same order, one per cycle.
- rsp_ready=0 and req0 valid continuously -> exactly FIFO_DEPTH=4 grants, then req0_ready=0. Raise rsp_ready -> 4 responses in order, and grants resume one cycle after the first pop.
- req1 granted with exp=255, uf=0 -> rsp_of=1, rsp_sig=0. A following normal op's result is uncorrupted.
- Reset asserted with 2 ops in flight and 1 in the FIFO -> no rsp_valid after reset; the first new contention grants req0.
- With FPU_MUL_FLUSH_EN: flush for 1 cycle with 3 ops outstanding -> rsp_valid=0 next cycle; a later request completes normally with correct tag.

Source files
------------

// File: rtl/fpu_mul_arbiter.sv
// fpu_mul_arbiter
// Shares one pipelined FPU multiply datapath (24x24 significand multiplier
// followed by the multiply normalizer) between two requesters.
//  - Round-robin arbitration; the operands of the granted request are driven
//    to the multiplier in the grant cycle.
//  - Each operation's pre-normalisation exponent and underflow flag travel
//    through a MUL_LAT-deep metadata pipe, so they reach the normalizer in the
//    same cycle as the product.
//  - Normalised results land in a credit-protected FIFO of depth MUL_LAT+2.
//    Results leave in grant order with requester id and tag under a
//    valid/ready handshake.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   flush                  (only with FPU_MUL_FLUSH_EN) drop all outstanding ops
//   reqN_valid/ready       request handshake, N in {0,1}
//   reqN_tag/exp/uf        opaque tag, biased pre-norm exponent, underflow flag
//   reqN_sigA/sigB         significands with hidden bit
//   mul_sig_A/B            operands to the multiplier (0 when nothing is granted)
//   mul_preNorm_exp        exponent to the normalizer, aligned with the product
//   mul_is_exp_underFlow   underflow flag to the normalizer, aligned with the product
//   mul_proNorm_sig/exp    normalizer result
//   mul_of/mul_uf          normalizer overflow/underflow
//   rsp_*                  result handshake and fields
//
// Build option: define FPU_MUL_FLUSH_EN to add the flush input.

module fpu_mul_arbiter #(
   parameter int MUL_LAT = 2,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
`ifdef FPU_MUL_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic [8:0]       req0_exp,
   input  logic             req0_uf,
   input  logic [23:0]      req0_sigA,
   input  logic [23:0]      req0_sigB,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [TAG_W-1:0] req1_tag,
   input  logic [8:0]       req1_exp,
   input  logic             req1_uf,
   input  logic [23:0]      req1_sigA,
   input  logic [23:0]      req1_sigB,
   output logic [23:0]      mul_sig_A,
   output logic [23:0]      mul_sig_B,
   output logic [8:0]       mul_preNorm_exp,
   output logic             mul_is_exp_underFlow,
   input  logic [25:0]      mul_proNorm_sig,
   input  logic [7:0]       mul_proNorm_exp,
   input  logic             mul_of,
   input  logic             mul_uf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [25:0]      rsp_sig,
   output logic [7:0]       rsp_exp,
   output logic             rsp_of,
   output logic             rsp_uf
);

   localparam int FIFO_DEPTH = MUL_LAT + 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic             valid;
      logic             id;
      logic [TAG_W-1:0] tag;
      logic [8:0]       exp;
      logic             uf;
   } meta_t;

   typedef struct packed {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic [25:0]      sig;
      logic [7:0]       exp;
      logic             of;
      logic             uf;
   } entry_t;

   logic             flushNow;
   logic [CNT_W-1:0] creditCnt;
   logic             lastGrant;
   meta_t            metaPipe [MUL_LAT];
   entry_t           fifoMem  [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] fifoOcc;

   logic             creditOk;
   logic             pick0;
   logic             pick1;
   logic             grantValid;
   meta_t            grantMeta;
   meta_t            metaLast;
   logic             landValid;
   logic             push;
   logic             pop;
   entry_t           pushEntry;
   entry_t           headEntry;

`ifdef FPU_MUL_FLUSH_EN
   assign flushNow = flush;
`else
   assign flushNow = 1'b0;
`endif

   // Credit covers in-flight ops plus FIFO occupancy, so every product that
   // lands is guaranteed a FIFO slot. A pop in the same cycle is not counted.
   assign creditOk = !reset && !flushNow && (creditCnt < CNT_W'(FIFO_DEPTH));

   // lastGrant == 1 means req1 was granted last, so req0 wins a contention.
   assign pick0 = req0_valid && (!req1_valid || lastGrant);
   assign pick1 = req1_valid && (!req0_valid || !lastGrant);

   assign req0_ready = creditOk && pick0;
   assign req1_ready = creditOk && pick1;
   assign grantValid = req0_ready || req1_ready;

   always_comb begin
      mul_sig_A = '0;
      mul_sig_B = '0;
      grantMeta = '0;
      if (req0_ready) begin
         mul_sig_A = req0_sigA;
         mul_sig_B = req0_sigB;
         grantMeta = '{valid: 1'b1, id: 1'b0, tag: req0_tag, exp: req0_exp, uf: req0_uf};
      end else if (req1_ready) begin
         mul_sig_A = req1_sigA;
         mul_sig_B = req1_sigB;
         grantMeta = '{valid: 1'b1, id: 1'b1, tag: req1_tag, exp: req1_exp, uf: req1_uf};
      end
   end

   assign metaLast             = metaPipe[MUL_LAT-1];
   assign landValid            = metaLast.valid && !reset;
   assign mul_preNorm_exp      = landValid ? metaLast.exp : 9'd0;
   assign mul_is_exp_underFlow = landValid && metaLast.uf;

   assign push      = landValid;
   assign pushEntry = '{id: metaLast.id, tag: metaLast.tag, sig: mul_proNorm_sig,
                        exp: mul_proNorm_exp, of: mul_of, uf: mul_uf};

   assign rsp_valid = (fifoOcc != '0) && !reset;
   assign pop       = rsp_valid && rsp_ready;
   assign headEntry = fifoMem[rdPtr];

   // Fields are forced to 0 when empty so stale entries never show.
   assign rsp_id  = rsp_valid && headEntry.id;
   assign rsp_tag = rsp_valid ? headEntry.tag : '0;
   assign rsp_sig = rsp_valid ? headEntry.sig : 26'd0;
   assign rsp_exp = rsp_valid ? headEntry.exp : 8'd0;
   assign rsp_of  = rsp_valid && headEntry.of;
   assign rsp_uf  = rsp_valid && headEntry.uf;

   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr] <= pushEntry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MUL_LAT; i++) begin
            metaPipe[i] <= '0;
         end
         lastGrant <= 1'b1;
         creditCnt <= '0;
         fifoOcc   <= '0;
         wrPtr     <= '0;
         rdPtr     <= '0;
      end else begin
         metaPipe[0] <= grantMeta;
         for (int i = 1; i < MUL_LAT; i++) begin
            metaPipe[i] <= metaPipe[i-1];
         end
         if (grantValid) begin
            lastGrant <= req1_ready;
         end
         if (push) begin
            wrPtr <= (wrPtr == PTR_W'(FIFO_DEPTH-1)) ? '0 : wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtr <= (rdPtr == PTR_W'(FIFO_DEPTH-1)) ? '0 : rdPtr + PTR_W'(1);
         end
         fifoOcc   <= fifoOcc + CNT_W'(push) - CNT_W'(pop);
         creditCnt <= creditCnt + CNT_W'(grantValid) - CNT_W'(pop);
         // Flush drops everything outstanding but keeps the arbitration order.
         if (flushNow) begin
            for (int i = 0; i < MUL_LAT; i++) begin
               metaPipe[i].valid <= 1'b0;
            end
            creditCnt <= '0;
            fifoOcc   <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
         end
      end
   end

endmodule
